// File: rtl/rec_ctrl.sv
// Bit clock recovery sequencer: acquires the minimum edge interval, tracks it in LOCK,
// and drives the recovered-clock NCO limit, resync and phase-flip controls.
module rec_ctrl #(
  parameter int W            = 16,
  parameter int INIT_PERIOD  = 801,
  parameter int MIN_INTERVAL = 4,
  parameter int ACQ_EDGES    = 16,
  parameter int STABLE_EDGES = 15,
  parameter int LOSS_TIMEOUT = 60000
) (
  input  logic         clk_300M,
  input  logic         rst,
  input  logic         enable,
  input  logic         edge_valid,
  input  logic [W-1:0] edge_interval,
  input  logic         type_req,
  input  logic         rev_req,
  output logic [W-1:0] period,
  output logic [W-1:0] nco_limit,
  output logic         div_sel,
  output logic         locked,
  output logic         nco_resync,
  output logic         phase_flip,
  output logic [1:0]   state_dbg
);

  localparam int CW = $clog2(LOSS_TIMEOUT + 1);
  localparam int AW = $clog2(ACQ_EDGES + 1);
  localparam int SW = $clog2(STABLE_EDGES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [W-1:0]  INIT_P   = W'(INIT_PERIOD);
  localparam logic [W-1:0]  MIN_I    = W'(MIN_INTERVAL);
  localparam logic [W-1:0]  ALL_ONES = {W{1'b1}};
  localparam logic [CW-1:0] TMO      = CW'(LOSS_TIMEOUT);
  localparam logic [AW-1:0] ACQ_N    = AW'(ACQ_EDGES);
  localparam logic [SW-1:0] STB_N    = SW'(STABLE_EDGES);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  period_q, period_d;
  logic [W-1:0]  limit_q, limit_d;
  logic [W-1:0]  min_q, min_d;
  logic [AW-1:0] acq_q, acq_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [CW-1:0] idle_q, idle_d;
  logic          div_sel_q, div_sel_d;
  logic          locked_q, resync_q, resync_d, flip_q;

  logic          valid_s, timeout_s;
  logic [W-1:0]  min_new_s, limit_src_s;
  logic [AW-1:0] acq_inc_s;
  logic [SW-1:0] stable_inc_s;

  always_comb begin
    valid_s      = edge_valid && (edge_interval >= MIN_I);
    timeout_s    = (idle_q == TMO);
    min_new_s    = (edge_interval < min_q) ? edge_interval : min_q;
    acq_inc_s    = acq_q + AW'(1);
    stable_inc_s = stable_q + SW'(1);
    state_d      = state_q;
    period_d     = period_q;
    min_d        = min_q;
    acq_d        = acq_q;
    stable_d     = stable_q;
    resync_d     = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ACQ;
          min_d   = ALL_ONES;
          acq_d   = '0;
        end
        S_ACQ: begin
          if (valid_s) begin
            min_d = min_new_s;
            acq_d = acq_inc_s;
            // The edge completing the acquisition is already folded into min_new_s.
            if (acq_inc_s == ACQ_N) begin
              state_d  = S_LOCK;
              period_d = min_new_s;
              stable_d = '0;
            end else begin
              state_d = S_ACQ;
            end
          end else if (timeout_s) begin
            min_d = ALL_ONES;
            acq_d = '0;
          end else begin
            state_d = S_ACQ;
          end
        end
        S_LOCK: begin
          if (valid_s) begin
            resync_d = 1'b1;
            if (edge_interval < period_q) begin
              period_d = edge_interval;
              stable_d = '0;
            end else if (stable_inc_s == STB_N) begin
              period_d = (period_q == ALL_ONES) ? period_q : period_q + W'(1);
              stable_d = '0;
            end else begin
              stable_d = stable_inc_s;
            end
          end else if (timeout_s) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_LOCK;
          end
        end
        S_HOLD: begin
          if (valid_s) begin
            state_d = S_ACQ;
            min_d   = ALL_ONES;
            acq_d   = '0;
          end else begin
            state_d = S_HOLD;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (valid_s || (state_d != state_q)) begin
      idle_d = '0;
    end else if (idle_q != TMO) begin
      idle_d = idle_q + CW'(1);
    end else begin
      idle_d = idle_q;
    end

    div_sel_d   = div_sel_q ^ type_req;
    limit_src_s = div_sel_q ? period_q : (period_q >> 1);
    limit_d     = (limit_src_s == '0) ? W'(1) : limit_src_s;
  end

  always_ff @(posedge clk_300M) begin
    if (rst) begin
      state_q   <= S_IDLE;
      period_q  <= INIT_P;
      limit_q   <= INIT_P >> 1;
      min_q     <= ALL_ONES;
      acq_q     <= '0;
      stable_q  <= '0;
      idle_q    <= '0;
      div_sel_q <= 1'b0;
      locked_q  <= 1'b0;
      resync_q  <= 1'b0;
      flip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      limit_q   <= limit_d;
      min_q     <= min_d;
      acq_q     <= acq_d;
      stable_q  <= stable_d;
      idle_q    <= idle_d;
      div_sel_q <= div_sel_d;
      locked_q  <= (state_d == S_LOCK);
      resync_q  <= resync_d;
      flip_q    <= rev_req;
    end
  end

  assign period     = period_q;
  assign nco_limit  = limit_q;
  assign div_sel    = div_sel_q;
  assign locked     = locked_q;
  assign nco_resync = resync_q;
  assign phase_flip = flip_q;
  assign state_dbg  = state_q;

endmodule
